// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and default width.
// No logic; pure declarations.
// Imported by serial_adder and its testbench.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial adder's per-cycle datapath.
// Latency: purely combinational.
// No flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single full adder.
// Latency: done pulses WIDTH+1 cycles after the cycle in which start is accepted.
// start is only sampled in IDLE/DONE; requests during SHIFT are dropped.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    // Operand A register doubles as the sum accumulator: as A shifts right,
    // each new sum bit enters at the MSB, so after WIDTH shifts it holds A+B.
    logic [WIDTH-1:0] acc_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_ff;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (acc_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_ff),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // FSM, shift datapath and result registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            acc_sr   <= '0;
            b_sr     <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc_sr   <= ip1;
                        b_sr     <= ip2;
                        carry_ff <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc_sr   <= {fa_s, acc_sr[WIDTH-1:1]};
                    b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                    carry_ff <= fa_cout;
                    cnt      <= cnt + CW'(1);
                    if (last_bit) begin
                        // Results only move on entry to DONE and hold afterwards.
                        sum_q   <= {fa_s, acc_sr[WIDTH-1:1]};
                        carry_q <= fa_cout;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_SHIFT);
    assign done  = (state == ST_DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule
